// File: rtl/ibex_pkg.sv
// Shared types and constants for the writeback buffer.
package ibex_pkg;

    localparam int unsigned WbDepthDefault = 2;
    localparam int unsigned RegAddrW       = 5;
    localparam int unsigned DataW          = 32;

    // One writeback buffer slot
    typedef struct packed {
        logic                valid;
        logic                we;
        logic [RegAddrW-1:0] waddr;
        logic [DataW-1:0]    wdata;
        logic                is_load;
        logic                data_rdy;
        logic                err;
    } wb_entry_t;

endpackage

// File: rtl/ibex_wb_fwd_match.sv
// Youngest-first forwarding search over the writeback buffer entries.
module ibex_wb_fwd_match
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = WbDepthDefault
) (
    input  wb_entry_t [Depth-1:0]                     entries_i,
    input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] tail_i,
    input  logic [4:0]                                raddr_i,
    output logic                                      hit_o,
    output logic                                      stall_o,
    output logic [31:0]                               wdata_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0] scan_idx;
    logic            unused_fields;

    // Walk oldest to youngest starting at the tail so the last match (youngest) wins
    always_comb begin
        hit_o    = 1'b0;
        stall_o  = 1'b0;
        wdata_o  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < Depth; k++) begin
            scan_idx = PtrW'((32'(tail_i) + k) % Depth);
            if (entries_i[scan_idx].valid && entries_i[scan_idx].we &&
                (entries_i[scan_idx].waddr != '0) &&
                (entries_i[scan_idx].waddr == raddr_i)) begin
                hit_o   = entries_i[scan_idx].data_rdy;
                stall_o = !entries_i[scan_idx].data_rdy;
                wdata_o = entries_i[scan_idx].data_rdy ? entries_i[scan_idx].wdata : '0;
            end
        end
    end

    // Load/error flags play no part in the lookup
    always_comb begin
        unused_fields = 1'b0;
        for (int unsigned k = 0; k < Depth; k++) begin
            unused_fields = unused_fields ^ entries_i[k].is_load ^ entries_i[k].err;
        end
    end

endmodule

// File: rtl/ibex_wb_buffer.sv
// In-order writeback buffer between EX and the register file write port.
// Optional forwarding lookup enabled by defining IBEX_WB_FWD_EN.
module ibex_wb_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = WbDepthDefault
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_is_load_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic        flush_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        instr_done_o,
    output logic        load_err_o,
    input  logic [4:0]  fwd_raddr_i,
    output logic        fwd_hit_o,
    output logic        fwd_stall_o,
    output logic [31:0] fwd_wdata_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    wb_entry_t [Depth-1:0] entries_q, entries_d;
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic            fill_found;
    logic [PtrW-1:0] fill_idx, pend_idx;
    wb_entry_t       head_entry, new_entry;
    logic            resp_to_head, head_err, retire, enq;
    logic [31:0]     head_wdata;
    logic            unused_head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign ex_ready_o = (count_q != CntW'(Depth));

    // Locate the oldest stored load still waiting for its data
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        pend_idx   = '0;
        for (int unsigned k = 0; k < Depth; k++) begin
            pend_idx = PtrW'((32'(head_q) + k) % Depth);
            if (!fill_found && entries_q[pend_idx].valid &&
                entries_q[pend_idx].is_load && !entries_q[pend_idx].data_rdy) begin
                fill_found = 1'b1;
                fill_idx   = pend_idx;
            end
        end
    end

    // Head retire decision; a response for the head load bypasses straight to the RF
    always_comb begin
        head_entry   = entries_q[head_q];
        resp_to_head = lsu_resp_valid_i && fill_found && (fill_idx == head_q);
        head_err     = resp_to_head ? lsu_resp_err_i : head_entry.err;
        head_wdata   = resp_to_head ? lsu_rdata_i : head_entry.wdata;
        retire       = head_entry.valid && (head_entry.data_rdy || resp_to_head) && !flush_i;
        enq          = ex_valid_i && ex_ready_o && !flush_i;
    end

    assign unused_head  = head_entry.is_load;
    assign rf_we_o      = retire && head_entry.we && !head_err;
    assign rf_waddr_o   = retire ? head_entry.waddr : '0;
    assign rf_wdata_o   = retire ? head_wdata : '0;
    assign instr_done_o = retire;
    assign load_err_o   = retire && head_err;

    // Next buffer contents: response fill, head pop, tail push
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        new_entry = '0;
        if (flush_i) begin
            entries_d = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            if (lsu_resp_valid_i && fill_found && !resp_to_head) begin
                entries_d[fill_idx].wdata    = lsu_rdata_i;
                entries_d[fill_idx].data_rdy = 1'b1;
                entries_d[fill_idx].err      = lsu_resp_err_i;
            end
            if (retire) begin
                entries_d[head_q] = '0;
                head_d            = ptr_inc(head_q);
            end
            if (enq) begin
                new_entry.valid   = 1'b1;
                new_entry.we      = ex_we_i;
                new_entry.waddr   = ex_waddr_i;
                new_entry.is_load = ex_is_load_i;
                if (!ex_is_load_i) begin
                    new_entry.wdata    = ex_wdata_i;
                    new_entry.data_rdy = 1'b1;
                end else if (lsu_resp_valid_i && !fill_found) begin
                    new_entry.wdata    = lsu_rdata_i;
                    new_entry.data_rdy = 1'b1;
                    new_entry.err      = lsu_resp_err_i;
                end
                entries_d[tail_q] = new_entry;
                tail_d            = ptr_inc(tail_q);
            end
            count_d = count_q + CntW'(enq) - CntW'(retire);
        end
    end

    // Buffer state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

`ifdef IBEX_WB_FWD_EN
    ibex_wb_fwd_match #(
        .Depth (Depth)
    ) u_fwd_match (
        .entries_i (entries_q),
        .tail_i    (tail_q),
        .raddr_i   (fwd_raddr_i),
        .hit_o     (fwd_hit_o),
        .stall_o   (fwd_stall_o),
        .wdata_o   (fwd_wdata_o)
    );
`else
    logic unused_fwd_raddr;
    assign unused_fwd_raddr = ^fwd_raddr_i;
    assign fwd_hit_o        = 1'b0;
    assign fwd_stall_o      = 1'b0;
    assign fwd_wdata_o      = '0;
`endif

    // Every LSU response must land on a pending load
    resp_not_dropped: assert property (@(posedge clk_i) disable iff (rst_i)
        lsu_resp_valid_i |-> (fill_found || (enq && ex_is_load_i)));

    // Flushing with an outstanding load would orphan its response
    flush_no_pending: assert property (@(posedge clk_i) disable iff (rst_i)
        flush_i |-> !fill_found);

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// Directed bench for ibex_wb_buffer (Depth=2).
module tb_ibex_wb_buffer;

`ifdef IBEX_WB_FWD_EN
    localparam bit FwdOn = 1'b1;
`else
    localparam bit FwdOn = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        ex_valid_i, ex_ready_o, ex_we_i, ex_is_load_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_resp_valid_i, lsu_resp_err_i;
    logic [31:0] lsu_rdata_i;
    logic        flush_i;
    logic        rf_we_o, instr_done_o, load_err_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  fwd_raddr_i;
    logic        fwd_hit_o, fwd_stall_o;
    logic [31:0] fwd_wdata_o;

    ibex_wb_buffer #(.Depth(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_we_i          (ex_we_i),
        .ex_waddr_i       (ex_waddr_i),
        .ex_wdata_i       (ex_wdata_i),
        .ex_is_load_i     (ex_is_load_i),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_resp_err_i   (lsu_resp_err_i),
        .lsu_rdata_i      (lsu_rdata_i),
        .flush_i          (flush_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .instr_done_o     (instr_done_o),
        .load_err_o       (load_err_o),
        .fwd_raddr_i      (fwd_raddr_i),
        .fwd_hit_o        (fwd_hit_o),
        .fwd_stall_o      (fwd_stall_o),
        .fwd_wdata_o      (fwd_wdata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v, we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ld, rv, rerr;
        logic [31:0] rdata;
        logic        fl;
        logic [4:0]  raddr;
        logic        e_rdy, e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_done, e_err, e_hit, e_stall;
        logic [31:0] e_fwd;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_rf(input string name, input logic rdy, input logic we,
                            input logic [4:0] waddr, input logic [31:0] wdata,
                            input logic done, input logic err);
        chk({name, ".ready"}, 32'(ex_ready_o), 32'(rdy));
        chk({name, ".rf_we"}, 32'(rf_we_o), 32'(we));
        chk({name, ".rf_waddr"}, 32'(rf_waddr_o), 32'(waddr));
        chk({name, ".rf_wdata"}, rf_wdata_o, wdata);
        chk({name, ".done"}, 32'(instr_done_o), 32'(done));
        chk({name, ".load_err"}, 32'(load_err_o), 32'(err));
    endtask

    task automatic check_fwd(input string name, input logic hit, input logic stall,
                             input logic [31:0] wdata);
        chk({name, ".fwd_hit"}, 32'(fwd_hit_o), 32'(FwdOn ? hit : 1'b0));
        chk({name, ".fwd_stall"}, 32'(fwd_stall_o), 32'(FwdOn ? stall : 1'b0));
        chk({name, ".fwd_wdata"}, fwd_wdata_o, FwdOn ? wdata : 32'h0);
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic ld, input logic rv,
                         input logic rerr, input logic [31:0] rdata, input logic fl);
        ex_valid_i       = v;
        ex_we_i          = we;
        ex_waddr_i       = waddr;
        ex_wdata_i       = wdata;
        ex_is_load_i     = ld;
        lsu_resp_valid_i = rv;
        lsu_resp_err_i   = rerr;
        lsu_rdata_i      = rdata;
        flush_i          = fl;
    endtask

    initial begin
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0);
        fwd_raddr_i = '0;
        rst_i       = 1'b1;

        // inputs: v we waddr wdata ld rv rerr rdata fl raddr | rdy we waddr wdata done err | hit stall fwd
        // single ALU op retires next cycle
        vecs.push_back('{'1,'1,5'd5,32'h1234,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'1,5'd5,32'h1234,'1,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        // load x6 blocks ALU x7; full buffer refuses x13 even while retiring
        vecs.push_back('{'1,'1,5'd6,32'hFFFF,'1,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'1,'1,5'd7,32'hA,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'1,'1,5'd13,32'hBAD,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'1,'1,5'd13,32'hBAD,'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'1,'1,5'd13,32'hBAD,'0,'1,'0,32'hDEADBEEF,'0,'0, '0,'1,5'd6,32'hDEADBEEF,'1,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'1,5'd7,32'hA,'1,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        // response in the enqueue cycle
        vecs.push_back('{'1,'1,5'd8,'0,'1,'1,'0,32'h55,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'1,5'd8,32'h55,'1,'0, '0,'0,'0});
        // load error suppresses the write
        vecs.push_back('{'1,'1,5'd9,'0,'1,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'1,'1,32'h77,'0,'0, '1,'0,5'd9,32'h77,'1,'1, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        // x0 retires normally and is never forwarded
        vecs.push_back('{'1,'1,5'd0,32'h99,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'1,5'd0,32'h99,'1,'0, '0,'0,'0});
        // non-writing op
        vecs.push_back('{'1,'0,5'd3,32'h33,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'0,5'd3,32'h33,'1,'0, '0,'0,'0});
        // flush kills both the retire and the enqueue
        vecs.push_back('{'1,'1,5'd10,32'h10,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'1,'1,5'd11,32'h11,'0,'0,'0,'0,'1,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        // forwarding of x3
        vecs.push_back('{'1,'1,5'd3,'0,'1,'0,'0,'0,'0,5'd3, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'1,'1,5'd3,32'h2,'0,'0,'0,'0,'0,5'd3, '1,'0,'0,'0,'0,'0, '0,'1,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,5'd3, '0,'0,'0,'0,'0,'0, '1,'0,32'h2});
        vecs.push_back('{'0,'0,'0,'0,'0,'1,'0,32'h111,'0,5'd3, '0,'1,5'd3,32'h111,'1,'0, '1,'0,32'h2});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,5'd3, '1,'1,5'd3,32'h2,'1,'0, '1,'0,32'h2});
        vecs.push_back('{'1,'1,5'd3,32'h1,'0,'0,'0,'0,'0,5'd3, '1,'0,'0,'0,'0,'0, '0,'0,'0});
        vecs.push_back('{'1,'1,5'd3,'0,'1,'0,'0,'0,'0,5'd3, '1,'1,5'd3,32'h1,'1,'0, '1,'0,32'h1});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,5'd3, '1,'0,'0,'0,'0,'0, '0,'1,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'1,'0,32'h222,'0,5'd3, '1,'1,5'd3,32'h222,'1,'0, '0,'1,'0});
        vecs.push_back('{'0,'0,'0,'0,'0,'0,'0,'0,'0,5'd3, '1,'0,'0,'0,'0,'0, '0,'0,'0});

        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #3;
        check_rf("reset", '1, '0, '0, '0, '0, '0);
        check_fwd("reset", '0, '0, '0);

        foreach (vecs[i]) begin
            @(posedge clk_i);
            #1;
            drive(vecs[i].v, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ld,
                  vecs[i].rv, vecs[i].rerr, vecs[i].rdata, vecs[i].fl);
            fwd_raddr_i = vecs[i].raddr;
            #3;
            check_rf($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_waddr,
                     vecs[i].e_wdata, vecs[i].e_done, vecs[i].e_err);
            check_fwd($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_stall, vecs[i].e_fwd);
        end

        // ten back-to-back ALU ops with ex_valid_i held high wrap the pointers
        fwd_raddr_i = '0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk_i);
            #1;
            if (j < 10) drive('1, '1, 5'(16 + j), 32'(256 + j), '0, '0, '0, '0, '0);
            else        drive('0, '0, '0, '0, '0, '0, '0, '0, '0);
            #3;
            if (j >= 1 && j <= 10)
                check_rf($sformatf("wrap%0d", j), '1, '1, 5'(16 + j - 1), 32'(256 + j - 1), '1, '0);
            else
                check_rf($sformatf("wrap%0d", j), '1, '0, '0, '0, '0, '0);
        end

        // reset discards a pending load; a later ALU op is not blocked by it
        @(posedge clk_i);
        #1 drive('1, '1, 5'd21, '0, '1, '0, '0, '0, '0);
        @(posedge clk_i);
        #1 drive('0, '0, '0, '0, '0, '0, '0, '0, '0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        drive('1, '1, 5'd22, 32'h22, '0, '0, '0, '0, '0);
        #3 check_rf("rst_mid.empty", '1, '0, '0, '0, '0, '0);
        @(posedge clk_i);
        #1 drive('0, '0, '0, '0, '0, '0, '0, '0, '0);
        #3 check_rf("rst_mid.retire", '1, '1, 5'd22, 32'h22, '1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
